// File: rtl/alu_arbiter.sv
// alu_arbiter -- two-requester front end for a single shared combinational ALU.
//
// Purpose:
//   Two requesters compete for one ALU. The arbiter grants one operation at a
//   time, registers its operands and control code toward the ALU (IDLE -> EXEC),
//   and one cycle later captures the ALU result and zero flag. It then returns a
//   one-cycle response pulse to the requester that owns the operation.
//   Peak throughput is one operation every two cycles. At most one operation is
//   in flight at any time.
//
// Configuration:
//   ALU_ARB_ROUND_ROBIN_EN -- when defined, simultaneous requests alternate
//   between the requesters. When undefined, requester 0 always wins a tie.
//
// Ports:
//   CLK                      rising-edge clock
//   Reset                    synchronous active-high reset
//   Req0Valid / Req1Valid    requester n presents an operation
//   Req0A, Req0B / Req1A, Req1B   requester n operands (WIDTH)
//   Req0Ctrl / Req1Ctrl      requester n ALU control code (4)
//   Req0Ready / Req1Ready    requester n operation accepted this cycle
//   AluA, AluB, AluCtrl      registered operands/control to the shared ALU
//   AluW, AluZero            combinational ALU result and zero flag
//   Resp0Valid / Resp1Valid  one-cycle result pulse to requester n
//   RespW, RespZero          registered result and zero flag (shared)

module alu_arbiter #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Req0Valid,
  input  logic [WIDTH-1:0] Req0A,
  input  logic [WIDTH-1:0] Req0B,
  input  logic [3:0]       Req0Ctrl,
  input  logic             Req1Valid,
  input  logic [WIDTH-1:0] Req1A,
  input  logic [WIDTH-1:0] Req1B,
  input  logic [3:0]       Req1Ctrl,
  output logic             Req0Ready,
  output logic             Req1Ready,
  output logic [WIDTH-1:0] AluA,
  output logic [WIDTH-1:0] AluB,
  output logic [3:0]       AluCtrl,
  input  logic [WIDTH-1:0] AluW,
  input  logic             AluZero,
  output logic             Resp0Valid,
  output logic             Resp1Valid,
  output logic [WIDTH-1:0] RespW,
  output logic             RespZero
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EXEC = 1'b1;

  logic [0:0] state_r;
  logic       owner_r;   // requester index of the operation in flight
  logic       grant_s;   // requester index that would win this cycle

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic       last_grant_r;

  // Last-grant pointer: moves only on an accepted handshake; reset favours requester 0.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      last_grant_r <= 1'b1;
    end else if (Req0Ready) begin
      last_grant_r <= 1'b0;
    end else if (Req1Ready) begin
      last_grant_r <= 1'b1;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  // Grant selection: a tie goes to the requester that was not served last.
  always_comb begin
    grant_s = 1'b0;
    if (Req0Valid && Req1Valid) begin
      grant_s = ~last_grant_r;
    end else if (Req1Valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end
`else
  // Grant selection: fixed priority, requester 0 always wins a tie.
  always_comb begin
    grant_s = 1'b0;
    if (Req0Valid) begin
      grant_s = 1'b0;
    end else if (Req1Valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end
`endif

  // Ready handshake: only in IDLE and out of reset, so at most one Ready is high.
  always_comb begin
    Req0Ready = 1'b0;
    Req1Ready = 1'b0;
    if (!Reset && (state_r == IDLE)) begin
      Req0Ready = Req0Valid && (grant_s == 1'b0);
      Req1Ready = Req1Valid && (grant_s == 1'b1);
    end else begin
      Req0Ready = 1'b0;
      Req1Ready = 1'b0;
    end
  end

  // FSM, ALU operand registers and response capture.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_r    <= IDLE;
      owner_r    <= 1'b0;
      AluA       <= {WIDTH{1'b0}};
      AluB       <= {WIDTH{1'b0}};
      AluCtrl    <= 4'b0000;
      RespW      <= {WIDTH{1'b0}};
      RespZero   <= 1'b0;
      Resp0Valid <= 1'b0;
      Resp1Valid <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          // Response pulses last exactly one cycle.
          Resp0Valid <= 1'b0;
          Resp1Valid <= 1'b0;
          if (Req0Ready) begin
            AluA    <= Req0A;
            AluB    <= Req0B;
            AluCtrl <= Req0Ctrl;
            owner_r <= 1'b0;
            state_r <= EXEC;
          end else if (Req1Ready) begin
            AluA    <= Req1A;
            AluB    <= Req1B;
            AluCtrl <= Req1Ctrl;
            owner_r <= 1'b1;
            state_r <= EXEC;
          end else begin
            state_r <= IDLE;
          end
        end
        EXEC: begin
          // The ALU has had a full cycle on the registered operands.
          RespW      <= AluW;
          RespZero   <= AluZero;
          Resp0Valid <= (owner_r == 1'b0);
          Resp1Valid <= (owner_r == 1'b1);
          state_r    <= IDLE;
        end
        default: begin
          state_r    <= IDLE;
          Resp0Valid <= 1'b0;
          Resp1Valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
